// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO that drains into the UART transmitter over a level-request / busy handshake.
// Requests that are not acknowledged within ACK_TIMEOUT cycles are dropped and flagged.
module uart_tx_fifo_feeder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned GAP_CYCLES  = 2,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic          sys_clk_100M,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_level,
    output logic          wr_overflow,
    output logic          tx_ready,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic          ack_err
);

    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(ACK_TIMEOUT);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StGap} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full_q, empty_q, ovf_q;
    logic [CW-1:0] ack_cnt_q, ack_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          tx_ready_q, tx_ready_d;
    logic          ack_err_q, ack_err_d;
    logic [7:0]    tx_data_q;
    logic          push, pop;

    // Full is the registered flag, so a pop in the same cycle does not free a slot early.
    assign push = wr_en & ~full_q;

    always_comb begin
        state_d    = state_q;
        tx_ready_d = 1'b0;
        ack_err_d  = 1'b0;
        ack_cnt_d  = ack_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    tx_ready_d = 1'b1;
                    ack_cnt_d  = '0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (tx_busy) begin
                    state_d = StDone;
                end else if (ack_cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    ack_err_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else begin
                    tx_ready_d = 1'b1;
                    ack_cnt_d  = ack_cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (!tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign level_d = level_q + LW'(push) - LW'(pop);

    always_ff @(posedge sys_clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            ack_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tx_ready_q <= 1'b0;
            ack_err_q  <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_ready_q <= tx_ready_d;
            ack_err_q  <= ack_err_d;
            level_q    <= level_d;
            full_q     <= (level_d == LW'(DEPTH));
            empty_q    <= (level_d == '0);
            ovf_q      <= wr_en & full_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge sys_clk_100M) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign fifo_full   = full_q;
    assign fifo_empty  = empty_q;
    assign fifo_level  = level_q;
    assign wr_overflow = ovf_q;
    assign tx_ready    = tx_ready_q;
    assign tx_data     = tx_data_q;
    assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench for uart_tx_fifo_feeder: queue-based handshake model checked every cycle,
// directed scenarios with literal expectations, and a randomized transmitter.
module tb_uart_tx_fifo_feeder;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned ACK_TIMEOUT = 8;
    localparam int unsigned GAP_CYCLES  = 2;
    localparam int unsigned AW          = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx_busy = 1'b0;
    logic          fifo_full, fifo_empty, wr_overflow, tx_ready, ack_err;
    logic [AW:0]   fifo_level;
    logic [7:0]    tx_data;

    int checks = 0;
    int errors = 0;

    // Model state: queued bytes plus the handshake phase the block is in.
    logic [7:0] q[$];
    logic [7:0] m_tx_data;
    bit         m_ready, m_ack, m_ovf, m_frame;
    int         m_age, m_gap;

    logic [7:0] dut_out[$];
    bit         prev_ready = 1'b0;
    bit         auto_xmit = 1'b0;
    bit         allow_drop = 1'b0;
    int         xm_wait = 0;
    int         xm_busy_left = 0;

    uart_tx_fifo_feeder #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .sys_clk_100M (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_level   (fifo_level),
        .wr_overflow  (wr_overflow),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .ack_err      (ack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_tx_data = 8'h00;
        m_ready   = 1'b0;
        m_ack     = 1'b0;
        m_ovf     = 1'b0;
        m_frame   = 1'b0;
        m_age     = 0;
        m_gap     = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT sampled at this edge.
    task automatic model_step();
        int pre;
        if (!rst_n) return;
        pre   = q.size();
        m_ack = 1'b0;
        m_ovf = wr_en && (pre == DEPTH);
        if (m_ready) begin
            if (tx_busy) begin
                m_ready = 1'b0;
                m_frame = 1'b1;
            end else if (m_age == ACK_TIMEOUT - 1) begin
                m_ready = 1'b0;
                m_ack   = 1'b1;
                m_gap   = GAP_CYCLES;
            end else begin
                m_age++;
            end
        end else if (m_frame) begin
            if (!tx_busy) begin
                m_frame = 1'b0;
                m_gap   = GAP_CYCLES;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (pre > 0) begin
            m_tx_data = q.pop_front();
            m_ready   = 1'b1;
            m_age     = 0;
        end
        if (wr_en && pre != DEPTH) q.push_back(wr_data);
    endtask

    task automatic compare_all();
        chk("level", int'(fifo_level), q.size());
        chk("full", int'(fifo_full), int'(q.size() == DEPTH));
        chk("empty", int'(fifo_empty), int'(q.size() == 0));
        chk("overflow", int'(wr_overflow), int'(m_ovf));
        chk("tx_ready", int'(tx_ready), int'(m_ready));
        chk("tx_data", int'(tx_data), int'(m_tx_data));
        chk("ack_err", int'(ack_err), int'(m_ack));
        if (tx_ready && !prev_ready) dut_out.push_back(tx_data);
        prev_ready = tx_ready;
    endtask

    // Transmitter stand-in: acknowledges after a short random delay, or ignores the request.
    task automatic xmit_update();
        if (xm_busy_left > 0) begin
            xm_busy_left--;
            if (xm_busy_left == 0) tx_busy = 1'b0;
        end else if (tx_ready) begin
            if (xm_wait == 0) begin
                tx_busy      = 1'b1;
                xm_busy_left = int'($urandom_range(12, 2));
            end else begin
                xm_wait--;
            end
        end else begin
            xm_wait = (allow_drop && $urandom_range(5, 0) == 0) ? 1000
                                                                : int'($urandom_range(4, 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (auto_xmit) xmit_update();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (n < budget && !(q.size() == 0 && !m_ready && !m_frame && m_gap == 0
                               && xm_busy_left == 0)) begin
            step();
            n++;
        end
        chk("drain_bound", int'(n < budget), 1);
    endtask

    initial begin
        int hi;
        int cnt;
        model_clear();
        @(negedge clk);
        step_n(3);
        chk("rst_empty", int'(fifo_empty), 1);
        chk("rst_ready", int'(tx_ready), 0);
        chk("rst_data", int'(tx_data), 0);
        rst_n = 1'b1;
        step_n(2);

        // Single byte: request one cycle after the write, held until busy.
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        chk("a5_level1", int'(fifo_level), 1);
        chk("a5_ready_lo", int'(tx_ready), 0);
        wr_en = 1'b0;
        step();
        chk("a5_ready", int'(tx_ready), 1);
        chk("a5_data", int'(tx_data), 8'hA5);
        chk("a5_level0", int'(fifo_level), 0);
        step_n(2);
        chk("a5_hold", int'(tx_ready), 1);
        tx_busy = 1'b1;
        step();
        chk("a5_drop", int'(tx_ready), 0);
        chk("a5_data_stable", int'(tx_data), 8'hA5);
        step_n(6);
        tx_busy = 1'b0;
        step_n(6);

        // Ack timeout: request high exactly ACK_TIMEOUT cycles, one error pulse.
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        hi = 0; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            hi  += int'(tx_ready);
            cnt += int'(ack_err);
        end
        chk("to_ready_cycles", hi, 8);
        chk("to_ack_pulses", cnt, 1);
        chk("to_level", int'(fifo_level), 0);

        // Fill / overflow with the transmitter stalled in a frame.
        tx_busy = 1'b1;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        step_n(3);
        cnt = 0;
        for (int i = 0; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            cnt += int'(wr_overflow);
        end
        wr_en = 1'b0;
        chk("fill_ovf_pulses", cnt, 1);
        chk("fill_full", int'(fifo_full), 1);
        chk("fill_level", int'(fifo_level), 16);
        tx_busy = 1'b0;
        dut_out.delete();
        auto_xmit = 1'b1;
        drain(2000);
        chk("fill_count", dut_out.size(), 16);
        for (int i = 0; i < 16; i++) chk("fill_order", int'(dut_out[i]), i);

        // Write on the pop cycle keeps the level at one.
        dut_out.delete();
        wr_en = 1'b1; wr_data = 8'h11;
        step();
        wr_data = 8'h3C;
        step();
        chk("sim_level", int'(fifo_level), 1);
        wr_en = 1'b0;
        drain(500);
        chk("sim_count", dut_out.size(), 2);
        chk("sim_first", int'(dut_out[0]), 8'h11);
        chk("sim_second", int'(dut_out[1]), 8'h3C);

        // Pointer wrap: two batches of ten.
        dut_out.delete();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 10; i++) begin
                wr_en = 1'b1; wr_data = 8'((b == 0 ? 8'h40 : 8'h80) + i);
                step();
            end
            wr_en = 1'b0;
            drain(1000);
        end
        chk("wrap_count", dut_out.size(), 20);
        for (int i = 0; i < 20; i++)
            chk("wrap_order", int'(dut_out[i]), (i < 10) ? 8'h40 + i : 8'h80 + i - 10);

        // Randomized traffic with occasional unacknowledged requests.
        allow_drop = 1'b1;
        for (int p = 0; p < 6; p++) begin
            int dens;
            dens = (p % 3 == 0) ? 5 : (p % 3 == 1) ? 30 : 90;
            for (int i = 0; i < 500; i++) begin
                wr_en   = ($urandom_range(99, 0) < dens);
                wr_data = 8'($urandom);
                step();
            end
        end
        wr_en = 1'b0;
        allow_drop = 1'b0;
        drain(3000);

        // Reset while in a frame with five bytes queued.
        auto_xmit = 1'b0;
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            step();
        end
        wr_en = 1'b0;
        chk("mid_level", int'(fifo_level), 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(tx_ready), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_empty", int'(fifo_empty), 1);
        model_clear();
        prev_ready = 1'b0;
        tx_busy = 1'b0;
        xm_busy_left = 0;
        step_n(3);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            hi += int'(tx_ready);
        end
        chk("post_rst_quiet", hi, 0);
        wr_en = 1'b1; wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        step();
        chk("post_rst_req", int'(tx_data), 8'h5A);
        step_n(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
